instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, encoded-word buffer entries (power of two, >=2).
REQ-002 SHALL have parameter: ADDR_W, 8, instruction-memory address width.
REQ-003 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: req_valid input 1 and req_ready output 1, the request handshake.
REQ-006 SHALL have port: req_kind  input  3  0 add, 1 sub, 2 and, 3 or, 4 mul, 5 load, 6 store, 7 reserved.
REQ-007 SHALL have ports: req_rs, req_rt, req_rd  input  5 each  register fields.
REQ-008 SHALL have port: req_imm  input  16  load/store offset.
REQ-009 SHALL have ports: start input 1 (pulse), base_addr input ADDR_W, stop input 1 (pulse).
REQ-010 SHALL have ports: mem_wr output 1, mem_addr output ADDR_W, mem_data output 32, mem_ready input 1.
REQ-011 SHALL have ports: busy output 1 (state RUN), err output 1 (sticky), count output ADDR_W+1 (words written).

Function
REQ-012 SHALL encode at acceptance (req_valid & req_ready) and push one 32-bit word into the FIFO.
REQ-013 R-type (kinds 0-4) SHALL encode [31:26]=1, [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=10, [5:0]=funct.
REQ-014 The funct values SHALL be add 32, sub 34, and 36, or 37, mul 50.
REQ-015 Load/store SHALL encode [31:26]=2/3, [25:21]=rs, [20:16]=rt, [15:0]=imm; rd ignored.
REQ-016 Reserved kind SHALL complete the handshake, push nothing, and set err.
REQ-017 req_ready SHALL equal !full and is independent of same-cycle dequeue.
REQ-018 Requests SHALL be accepted in both states; the FIFO fills while IDLE.
REQ-019 The FSM SHALL have states IDLE and RUN plus a stop_pending flag.
REQ-020 IDLE + start SHALL load mem_addr<=base_addr, clear count and err, and enter RUN next cycle.
REQ-021 start in RUN SHALL be ignored.
REQ-022 mem_wr SHALL equal RUN & !empty; mem_data SHALL be the FIFO head, combinational from storage.
REQ-023 A write SHALL complete on mem_wr & mem_ready: pop, mem_addr+1 wrapping modulo 2^ADDR_W, count+1.
REQ-024 count SHALL saturate at 2^ADDR_W.
REQ-025 mem_wr with !mem_ready SHALL hold mem_addr and mem_data stable.
REQ-026 stop in RUN SHALL set stop_pending; RUN->IDLE occurs the cycle the FIFO is empty with stop_pending, and stop_pending then clears.
REQ-027 Pushes during stop_pending SHALL also be drained before IDLE.
REQ-028 Push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-029 Latency from acceptance to mem_wr SHALL be 1 cycle when RUN and the FIFO was empty.
REQ-030 FIFO order SHALL be strict first-in first-out.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, FIFO empty, stop_pending 0, mem_addr 0, count 0, and err 0.
REQ-032 During reset, outputs SHALL be mem_wr 0, mem_data 0, busy 0, and req_ready 0.
REQ-033 After rst_n deasserts, req_ready SHALL be 1 from the first clock edge.
REQ-034 Reset mid-write SHALL discard the FIFO contents with no further mem_wr.

Verification
REQ-035 Bench SHALL cover: start, base_addr=0x10; add rs=1 rt=2 rd=3, mem_ready=1 -> mem_wr at addr 0x10, data 0x0422_1AA0, count=1.
REQ-036 Bench SHALL cover: load rs=4 rt=5 imm=0x0008, then store same -> data 0x0885_0008 then 0x0C85_0008 at consecutive addresses.
REQ-037 Bench SHALL cover: IDLE, 5 requests with FIFO_DEPTH=4 -> 4 accepted, req_ready=0; start -> 4 writes in order, 5th accepted after first pop.
REQ-038 Bench SHALL cover: base_addr=0xFE, 3 writes -> addresses 0xFE, 0xFF, 0x00, count=3.
REQ-039 Bench SHALL cover: kind 7 -> handshake completes, err=1, no mem_wr; next start -> err=0.
REQ-040 Bench SHALL cover: mem_ready=0 for 3 cycles then stop with 2 queued -> addr/data held, 2 writes, then busy=0; rst_n low mid-run -> mem_wr=0 immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: turns request tuples into 32-bit instruction words, buffers
// them in a small FIFO and streams them to instruction memory while in RUN.
module instr_encoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_kind,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [15:0]       req_imm,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              stop,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data,
   input  logic              mem_ready,
   output logic              busy,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic {IDLE, RUN} state_e;

   state_e               state_q, state_d;
   logic                 stop_pend_q, stop_pend_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [ADDR_W:0]      count_q, count_d;
   logic                 err_q, err_d;
   logic                 rdy_en_q;
   logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
   logic [31:0]          fifo_q [FIFO_DEPTH];

   logic empty, full, accept, push, pop, reserved;

   function automatic logic [5:0] funct_of(input logic [2:0] kind);
      logic [5:0] f;
      f = 6'd0;
      case (kind)
         3'd0:    f = 6'd32;
         3'd1:    f = 6'd34;
         3'd2:    f = 6'd36;
         3'd3:    f = 6'd37;
         3'd4:    f = 6'd50;
         default: f = 6'd0;
      endcase
      return f;
   endfunction

   function automatic logic [31:0] encode(input logic [2:0]  kind,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [4:0]  rd,
                                          input logic [15:0] imm);
      logic [31:0] w;
      w = 32'd0;
      case (kind)
         3'd5:    w = {6'd2, rs, rt, imm};
         3'd6:    w = {6'd3, rs, rt, imm};
         default: w = {6'd1, rs, rt, rd, 5'd10, funct_of(kind)};
      endcase
      return w;
   endfunction

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   // rdy_en_q holds req_ready low while in reset and until the first clock edge.
   assign req_ready = rdy_en_q & ~full;
   assign accept    = req_valid & req_ready;
   assign reserved  = (req_kind == 3'd7);
   assign push      = accept & ~reserved;
   assign mem_wr    = (state_q == RUN) & ~empty;
   assign pop       = mem_wr & mem_ready;
   assign mem_data  = empty ? 32'd0 : fifo_q[rd_ptr_q[PTR_W-1:0]];
   assign mem_addr  = addr_q;
   assign busy      = (state_q == RUN);
   assign err       = err_q;
   assign count     = count_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q[PTR_W-1:0]] <= encode(req_kind, req_rs, req_rt, req_rd, req_imm);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         stop_pend_q <= 1'b0;
         addr_q      <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         rdy_en_q    <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         stop_pend_q <= stop_pend_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         err_q       <= err_d;
         rdy_en_q    <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      stop_pend_d = stop_pend_q;
      addr_d      = addr_q;
      count_d     = count_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               addr_d  = base_addr;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         RUN: begin
            if (stop) stop_pend_d = 1'b1;
            if (pop) begin
               addr_d = addr_q + 1'b1;
               if (count_q != CNT_MAX) count_d = count_q + 1'b1;
            end
            if (stop_pend_q && empty) begin
               state_d     = IDLE;
               stop_pend_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      // A reserved request accepted alongside start still leaves err raised.
      if (accept && reserved) err_d = 1'b1;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding, FIFO back-pressure, address wrap,
// reserved-kind error, stall/stop draining and asynchronous reset.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_kind;
   logic [4:0]  req_rs, req_rt, req_rd;
   logic [15:0] req_imm;
   logic        start, stop;
   logic [7:0]  base_addr;
   logic        mem_wr;
   logic [7:0]  mem_addr;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic        busy, err;
   logic [8:0]  count;

   int checks = 0;
   int errors = 0;

   instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
      .start(start), .base_addr(base_addr), .stop(stop),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .busy(busy), .err(err), .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm);
      req_valid = 1'b1;
      req_kind  = k;
      req_rs    = rs;
      req_rt    = rt;
      req_rd    = rd;
      req_imm   = imm;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_kind = '0; req_rs = '0; req_rt = '0;
      req_rd = '0; req_imm = '0; start = 1'b0; stop = 1'b0; base_addr = '0;
      mem_ready = 1'b1;

      // Reset state
      #3;
      chk("rst_mem_wr",    {31'd0, mem_wr},    32'd0);
      chk("rst_mem_data",  mem_data,           32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_count",     {23'd0, count},     32'd0);
      chk("rst_err",       {31'd0, err},       32'd0);
      chk("rst_mem_addr",  {24'd0, mem_addr},  32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

      // add at base 0x10
      base_addr = 8'h10; start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", {31'd0, busy}, 32'd1);
      set_req(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
      tick();
      req_valid = 1'b0;
      chk("add_wr",   {31'd0, mem_wr},   32'd1);
      chk("add_addr", {24'd0, mem_addr}, 32'h10);
      chk("add_data", mem_data,          32'h0422_1AA0);
      tick();
      chk("add_count", {23'd0, count},   32'd1);
      chk("add_idle",  {31'd0, mem_wr},  32'd0);

      // load then store
      set_req(3'd5, 5'd4, 5'd5, 5'd0, 16'h0008);
      tick();
      chk("load_data", mem_data,          32'h0885_0008);
      chk("load_addr", {24'd0, mem_addr}, 32'h11);
      set_req(3'd6, 5'd4, 5'd5, 5'd0, 16'h0008);
      tick();
      req_valid = 1'b0;
      chk("store_data", mem_data,          32'h0C85_0008);
      chk("store_addr", {24'd0, mem_addr}, 32'h12);
      tick();
      chk("ls_count", {23'd0, count}, 32'd3);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      chk("stop_idle", {31'd0, busy}, 32'd0);

      // Fill while IDLE: 4 accepted, 5th waits
      for (int i = 0; i < 4; i++) begin
         set_req(3'd0, 5'd1, 5'd2, 5'(i), 16'h0);
         chk("fill_ready", {31'd0, req_ready}, 32'd1);
         tick();
      end
      set_req(3'd0, 5'd1, 5'd2, 5'd4, 16'h0);
      chk("full_ready", {31'd0, req_ready}, 32'd0);
      chk("idle_no_wr", {31'd0, mem_wr},    32'd0);
      tick();
      base_addr = 8'h20; start = 1'b1;
      tick();
      start = 1'b0;
      chk("q0_data", mem_data,          32'h0422_02A0);
      chk("q0_addr", {24'd0, mem_addr}, 32'h20);
      chk("q0_full", {31'd0, req_ready}, 32'd0);
      tick();
      chk("q1_data",  mem_data,           32'h0422_0AA0);
      chk("q1_ready", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      chk("q2_data", mem_data,          32'h0422_12A0);
      chk("q2_addr", {24'd0, mem_addr}, 32'h22);
      tick();
      chk("q3_data", mem_data, 32'h0422_1AA0);
      tick();
      chk("q4_data", mem_data,          32'h0422_22A0);
      chk("q4_addr", {24'd0, mem_addr}, 32'h24);
      tick();
      chk("q_done_wr",  {31'd0, mem_wr}, 32'd0);
      chk("q_count",    {23'd0, count},  32'd5);
      stop = 1'b1; tick(); stop = 1'b0; tick();

      // Address wrap from 0xFE
      base_addr = 8'hFE; start = 1'b1;
      tick();
      start = 1'b0;
      set_req(3'd3, 5'd0, 5'd0, 5'd0, 16'h0);
      tick();
      chk("wrap_a0",   {24'd0, mem_addr}, 32'hFE);
      chk("or_data",   mem_data,          32'h0400_02A5);
      tick();
      chk("wrap_a1", {24'd0, mem_addr}, 32'hFF);
      tick();
      req_valid = 1'b0;
      chk("wrap_a2", {24'd0, mem_addr}, 32'h00);
      chk("wrap_wr", {31'd0, mem_wr},   32'd1);
      tick();
      chk("wrap_count", {23'd0, count}, 32'd3);
      stop = 1'b1; tick(); stop = 1'b0; tick();

      // Reserved kind
      base_addr = 8'h40; start = 1'b1;
      tick();
      start = 1'b0;
      set_req(3'd7, 5'd1, 5'd1, 5'd1, 16'h0);
      chk("rsv_ready", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      chk("rsv_err", {31'd0, err},    32'd1);
      chk("rsv_nowr", {31'd0, mem_wr}, 32'd0);
      tick();
      chk("rsv_nowr2", {31'd0, mem_wr}, 32'd0);
      chk("rsv_count", {23'd0, count},  32'd0);
      stop = 1'b1; tick(); stop = 1'b0; tick();
      chk("rsv_idle", {31'd0, busy}, 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("err_cleared", {31'd0, err}, 32'd0);

      // Stall then stop with two queued
      mem_ready = 1'b0;
      set_req(3'd1, 5'd1, 5'd2, 5'd3, 16'h0);
      tick();
      set_req(3'd2, 5'd0, 5'd0, 5'd0, 16'h0);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stall_wr",   {31'd0, mem_wr},   32'd1);
         chk("stall_addr", {24'd0, mem_addr}, 32'h40);
         chk("stall_data", mem_data,          32'h0422_1AA2);
         tick();
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("pend_busy", {31'd0, busy}, 32'd1);
      mem_ready = 1'b1;
      tick();
      chk("drain_data", mem_data,          32'h0400_02A4);
      chk("drain_addr", {24'd0, mem_addr}, 32'h41);
      tick();
      chk("drain_empty", {31'd0, mem_wr}, 32'd0);
      chk("drain_busy",  {31'd0, busy},   32'd1);
      tick();
      chk("drain_idle",  {31'd0, busy},   32'd0);
      chk("drain_count", {23'd0, count},  32'd2);

      // Asynchronous reset mid-write
      base_addr = 8'h50; start = 1'b1;
      tick();
      start = 1'b0;
      mem_ready = 1'b0;
      set_req(3'd4, 5'd1, 5'd1, 5'd1, 16'h0);
      tick();
      req_valid = 1'b0;
      chk("pre_rst_wr", {31'd0, mem_wr}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr",    {31'd0, mem_wr},    32'd0);
      chk("mid_rst_busy",  {31'd0, busy},      32'd0);
      chk("mid_rst_data",  mem_data,           32'd0);
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      mem_ready = 1'b1;
      tick(); tick();
      chk("post_rst_wr",    {31'd0, mem_wr},    32'd0);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rst_count", {23'd0, count},     32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
